// File: rtl/ip_hchk_rx.sv
// IPv4 header receiver: captures a 20-byte header, verifies the ones'-complement checksum and
// header sanity fields, and holds the verdict plus parsed fields until the demux acknowledges.
module ip_hchk_rx #(
  parameter bit CHECK_DST    = 1'b1,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        ip_rx_clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_sof,
  input  logic [31:0] MyIP,
  input  logic        ip_rx_header_ack,
  output logic        ip_HeaderDone,
  output logic        ip_HeaderValid,
  output logic [4:0]  ip_HeaderErr,
  output logic [15:0] ip_total_len,
  output logic [15:0] ip_payload_len,
  output logic [7:0]  IpPro,
  output logic [31:0] IpSrcIP,
  output logic [31:0] IpDstIP
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StFold1   = 3'd2;
  localparam logic [2:0] StFold2   = 3'd3;
  localparam logic [2:0] StHold    = 3'd4;

  logic [2:0]   st_q, st_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [159:0] hdr_q, hdr_d;
  logic [31:0]  acc_q, acc_d;
  logic [16:0]  s1_q, s1_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic [4:0]   err_q, err_d;
  logic [15:0]  tl_q, tl_d;
  logic [15:0]  pl_q, pl_d;
  logic [7:0]   pro_q, pro_d;
  logic [31:0]  src_q, src_d;
  logic [31:0]  dst_q, dst_d;

  // Byte 0 of the header ends up in the top byte after 20 shifts.
  logic [7:0]  h_ver;
  logic [15:0] h_tl;
  logic [15:0] h_frag;
  logic [7:0]  h_pro;
  logic [31:0] h_src;
  logic [31:0] h_dst;
  assign h_ver  = hdr_q[159:152];
  assign h_tl   = hdr_q[143:128];
  assign h_frag = hdr_q[111:96];
  assign h_pro  = hdr_q[87:80];
  assign h_src  = hdr_q[63:32];
  assign h_dst  = hdr_q[31:0];

  logic        start;
  logic [15:0] s2;
  logic        dst_match;
  logic [4:0]  err_c;

  always_comb begin
    start     = rx_dv & rx_sof;
    s2        = s1_q[15:0] + {15'd0, s1_q[16]};
    dst_match = (h_dst == MyIP) || (ACCEPT_BCAST && (h_dst == 32'hFFFF_FFFF));
    err_c[0]  = (s2 != 16'hFFFF);
    err_c[1]  = (h_ver != 8'h45);
    err_c[2]  = CHECK_DST && !dst_match;
    err_c[3]  = h_frag[13] | (|h_frag[12:0]);
    err_c[4]  = (h_tl < 16'd20);
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    acc_d   = acc_q;
    s1_d    = s1_q;
    done_d  = done_q;
    valid_d = valid_q;
    err_d   = err_q;
    tl_d    = tl_q;
    pl_d    = pl_q;
    pro_d   = pro_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (st_q)
      StIdle: begin
        if (start) begin
          hdr_d = {hdr_q[151:0], rx_data};
          cnt_d = 5'd1;
          acc_d = 32'd0;
          st_d  = StCollect;
        end
      end
      StCollect: begin
        if (start) begin
          hdr_d = {hdr_q[151:0], rx_data};
          cnt_d = 5'd1;
          acc_d = 32'd0;
        end else if (rx_dv) begin
          hdr_d = {hdr_q[151:0], rx_data};
          cnt_d = cnt_q + 5'd1;
          // An odd count means this byte completes a 16-bit word with the previous one.
          if (cnt_q[0]) begin
            acc_d = acc_q + {16'd0, hdr_q[7:0], rx_data};
          end
          if (cnt_q == 5'd19) begin
            st_d = StFold1;
          end
        end
      end
      StFold1: begin
        s1_d = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
        st_d = StFold2;
      end
      StFold2: begin
        err_d   = err_c;
        valid_d = (err_c == 5'd0);
        tl_d    = h_tl;
        pl_d    = (h_tl < 16'd20) ? 16'd0 : (h_tl - 16'd20);
        pro_d   = h_pro;
        src_d   = h_src;
        dst_d   = h_dst;
        done_d  = 1'b1;
        st_d    = StHold;
      end
      StHold: begin
        if (start) begin
          done_d = 1'b0;
          hdr_d  = {hdr_q[151:0], rx_data};
          cnt_d  = 5'd1;
          acc_d  = 32'd0;
          st_d   = StCollect;
        end else if (ip_rx_header_ack) begin
          done_d = 1'b0;
          st_d   = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge ip_rx_clk or posedge reset) begin
    if (reset) begin
      st_q    <= StIdle;
      cnt_q   <= 5'd0;
      hdr_q   <= 160'd0;
      acc_q   <= 32'd0;
      s1_q    <= 17'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 5'd0;
      tl_q    <= 16'd0;
      pl_q    <= 16'd0;
      pro_q   <= 8'd0;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      acc_q   <= acc_d;
      s1_q    <= s1_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tl_q    <= tl_d;
      pl_q    <= pl_d;
      pro_q   <= pro_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign ip_HeaderDone  = done_q;
  assign ip_HeaderValid = valid_q;
  assign ip_HeaderErr   = err_q;
  assign ip_total_len   = tl_q;
  assign ip_payload_len = pl_q;
  assign IpPro          = pro_q;
  assign IpSrcIP        = src_q;
  assign IpDstIP        = dst_q;

endmodule

// File: tb/tb_ip_hchk_rx.sv
// Bench for ip_hchk_rx: three instances (default, no dst check, no broadcast) share one stimulus
// stream and are compared against a word-level header model.
module tb_ip_hchk_rx;

  typedef struct packed {
    logic        valid;
    logic [4:0]  err;
    logic [15:0] tl;
    logic [15:0] pl;
    logic [7:0]  pro;
    logic [31:0] src;
    logic [31:0] dst;
  } res_t;

  localparam logic [159:0] Good = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_sof;
  logic [31:0] myip;
  logic        ack;

  logic        done_w  [3];
  logic        valid_w [3];
  logic [4:0]  err_w   [3];
  logic [15:0] tl_w    [3];
  logic [15:0] pl_w    [3];
  logic [7:0]  pro_w   [3];
  logic [31:0] src_w   [3];
  logic [31:0] dst_w   [3];

  int   checks = 0;
  int   errors = 0;
  logic exp_done;
  res_t exp_res [3];

  always #5 clk = ~clk;

  ip_hchk_rx #(.CHECK_DST(1'b1), .ACCEPT_BCAST(1'b1)) u0 (
    .ip_rx_clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_sof(rx_sof),
    .MyIP(myip), .ip_rx_header_ack(ack), .ip_HeaderDone(done_w[0]),
    .ip_HeaderValid(valid_w[0]), .ip_HeaderErr(err_w[0]), .ip_total_len(tl_w[0]),
    .ip_payload_len(pl_w[0]), .IpPro(pro_w[0]), .IpSrcIP(src_w[0]), .IpDstIP(dst_w[0])
  );
  ip_hchk_rx #(.CHECK_DST(1'b0), .ACCEPT_BCAST(1'b1)) u1 (
    .ip_rx_clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_sof(rx_sof),
    .MyIP(myip), .ip_rx_header_ack(ack), .ip_HeaderDone(done_w[1]),
    .ip_HeaderValid(valid_w[1]), .ip_HeaderErr(err_w[1]), .ip_total_len(tl_w[1]),
    .ip_payload_len(pl_w[1]), .IpPro(pro_w[1]), .IpSrcIP(src_w[1]), .IpDstIP(dst_w[1])
  );
  ip_hchk_rx #(.CHECK_DST(1'b1), .ACCEPT_BCAST(1'b0)) u2 (
    .ip_rx_clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_sof(rx_sof),
    .MyIP(myip), .ip_rx_header_ack(ack), .ip_HeaderDone(done_w[2]),
    .ip_HeaderValid(valid_w[2]), .ip_HeaderErr(err_w[2]), .ip_total_len(tl_w[2]),
    .ip_payload_len(pl_w[2]), .IpPro(pro_w[2]), .IpSrcIP(src_w[2]), .IpDstIP(dst_w[2])
  );

  function automatic logic [7:0] byt(input logic [159:0] h, input int i);
    return h[159-8*i -: 8];
  endfunction

  function automatic logic [159:0] set_byte(input logic [159:0] h, input int i,
                                            input logic [7:0] v);
    logic [159:0] r;
    r = h;
    r[159-8*i -: 8] = v;
    return r;
  endfunction

  // Ones'-complement sum of the ten header words, fully folded.
  function automatic logic [15:0] ocsum(input logic [159:0] h);
    int unsigned s;
    s = 0;
    for (int j = 0; j < 10; j++) s += {byt(h, 2*j), byt(h, 2*j+1)};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [159:0] fix_csum(input logic [159:0] h);
    logic [159:0] r;
    logic [15:0]  c;
    r = set_byte(set_byte(h, 10, 8'h00), 11, 8'h00);
    c = ~ocsum(r);
    return set_byte(set_byte(r, 10, c[15:8]), 11, c[7:0]);
  endfunction

  function automatic res_t model(input logic [159:0] h, input logic [31:0] ip,
                                 input bit cd, input bit ab);
    res_t        r;
    logic [15:0] fl;
    fl     = {byt(h, 6), byt(h, 7)};
    r.tl   = {byt(h, 2), byt(h, 3)};
    r.pro  = byt(h, 9);
    r.src  = {byt(h, 12), byt(h, 13), byt(h, 14), byt(h, 15)};
    r.dst  = {byt(h, 16), byt(h, 17), byt(h, 18), byt(h, 19)};
    r.pl   = (r.tl < 20) ? 16'd0 : 16'(r.tl - 20);
    r.err[0] = (ocsum(h) != 16'hFFFF);
    r.err[1] = (byt(h, 0) != 8'h45);
    r.err[2] = cd && !((r.dst == ip) || (ab && r.dst == 32'hFFFF_FFFF));
    r.err[3] = fl[13] || (fl[12:0] != 0);
    r.err[4] = (r.tl < 20);
    r.valid  = (r.err == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.done", tag, k), 32'(done_w[k]), 32'(exp_done));
      chk($sformatf("%s.u%0d.valid", tag, k), 32'(valid_w[k]), 32'(exp_res[k].valid));
      chk($sformatf("%s.u%0d.err", tag, k), 32'(err_w[k]), 32'(exp_res[k].err));
      chk($sformatf("%s.u%0d.tl", tag, k), 32'(tl_w[k]), 32'(exp_res[k].tl));
      chk($sformatf("%s.u%0d.pl", tag, k), 32'(pl_w[k]), 32'(exp_res[k].pl));
      chk($sformatf("%s.u%0d.pro", tag, k), 32'(pro_w[k]), 32'(exp_res[k].pro));
      chk($sformatf("%s.u%0d.src", tag, k), src_w[k], exp_res[k].src);
      chk($sformatf("%s.u%0d.dst", tag, k), dst_w[k], exp_res[k].dst);
    end
  endtask

  task automatic send_bytes(input logic [159:0] h, input int first, input int last,
                            input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          rx_dv  = 1'b0;
          rx_sof = 1'b0;
        end
      end
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = byt(h, i);
      rx_sof  = (i == 0);
    end
  endtask

  // Byte 19 is sampled on the edge before the first negedge here; Done must appear only
  // after the second following edge.
  task automatic finish_hdr(input logic [159:0] h, input string tag);
    @(negedge clk);
    rx_dv  = 1'b0;
    rx_sof = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("%s.u%0d.early", tag, k), 32'(done_w[k]), 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) exp_res[k] = model(h, myip, k != 1, k != 2);
    exp_done = 1'b1;
    check_all(tag);
  endtask

  task automatic send_hdr(input logic [159:0] h, input bit gaps, input string tag);
    send_bytes(h, 0, 19, gaps);
    finish_hdr(h, tag);
  endtask

  task automatic pulse_ack(input string tag);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    exp_done = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [159:0] rand_hdr(input logic [31:0] ip);
    logic [159:0] h;
    logic [15:0]  tl;
    logic [15:0]  fl;
    logic [31:0]  dst;
    int           mode;
    tl  = 16'($urandom_range(20, 1500));
    fl  = ($urandom_range(0, 1) != 0) ? 16'h4000 : 16'h0000;
    dst = ($urandom_range(0, 2) == 0) ? 32'($urandom) : ip;
    if ($urandom_range(0, 5) == 0) dst = 32'hFFFF_FFFF;
    h = {8'h45, 8'($urandom), tl, 16'($urandom), fl, 8'($urandom), 8'($urandom), 16'h0,
         32'($urandom), dst};
    mode = $urandom_range(0, 5);
    if (mode == 1) h = set_byte(h, 0, 8'($urandom));
    if (mode == 2) h = set_byte(set_byte(h, 6, 8'($urandom)), 7, 8'($urandom));
    if (mode == 3) h = set_byte(set_byte(h, 2, 8'h00), 3, 8'($urandom_range(0, 25)));
    h = fix_csum(h);
    if (mode == 4) h = set_byte(h, 11, byt(h, 11) ^ 8'(1 << $urandom_range(0, 7)));
    return h;
  endfunction

  initial begin
    logic [159:0] h;
    logic [159:0] h2;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_dv    = 1'b0;
    rx_sof   = 1'b0;
    ack      = 1'b0;
    myip     = 32'hC0A8_00C7;
    exp_done = 1'b0;
    for (int k = 0; k < 3; k++) exp_res[k] = '0;

    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all("post_reset");

    send_hdr(Good, 1'b0, "good");
    chk("good.valid_lit", 32'(valid_w[0]), 1);
    chk("good.err_lit", 32'(err_w[0]), 0);
    chk("good.tl_lit", 32'(tl_w[0]), 32'h0073);
    chk("good.pl_lit", 32'(pl_w[0]), 32'h005F);
    chk("good.pro_lit", 32'(pro_w[0]), 32'h11);
    chk("good.src_lit", src_w[0], 32'hC0A8_0001);
    chk("good.dst_lit", dst_w[0], 32'hC0A8_00C7);
    pulse_ack("good_ack");

    h = set_byte(Good, 11, 8'h62);
    send_hdr(h, 1'b0, "bad_csum");
    chk("bad_csum.err_lit", 32'(err_w[0]), 32'b00001);
    chk("bad_csum.valid_lit", 32'(valid_w[0]), 0);
    pulse_ack("bad_csum_ack");

    myip = 32'hC0A8_0002;
    send_hdr(Good, 1'b0, "dst_miss");
    chk("dst_miss.err_lit", 32'(err_w[0]), 32'b00100);
    chk("dst_miss.nodst_valid", 32'(valid_w[1]), 1);
    pulse_ack("dst_miss_ack");
    myip = 32'hC0A8_00C7;

    h = fix_csum({Good[159:32], 32'hFFFF_FFFF});
    send_hdr(h, 1'b0, "bcast");
    chk("bcast.valid_lit", 32'(valid_w[0]), 1);
    chk("bcast.nobcast_err", 32'(err_w[2]), 32'b00100);

    // Partial header with gaps is abandoned by a fresh start of frame (from Hold).
    h2 = fix_csum({Good[159:64], 32'h0A00_0005, 32'hC0A8_00C7});
    h2 = fix_csum(set_byte(h2, 9, 8'h01));
    send_bytes(Good, 0, 6, 1'b1);
    @(negedge clk);
    rx_dv  = 1'b0;
    rx_sof = 1'b0;
    chk("restart.done_dropped", 32'(done_w[0]), 0);
    send_hdr(h2, 1'b1, "restart");
    chk("restart.pro_lit", 32'(pro_w[0]), 32'h01);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.done", c), 32'(done_w[0]), 1);
    end
    pulse_ack("restart_ack");

    send_hdr(fix_csum(set_byte(Good, 0, 8'h46)), 1'b0, "ver");
    chk("ver.err_lit", 32'(err_w[0]), 32'b00010);
    send_hdr(fix_csum(set_byte(set_byte(Good, 6, 8'h20), 7, 8'h00)), 1'b0, "frag");
    chk("frag.err_lit", 32'(err_w[0]), 32'b01000);
    send_hdr(fix_csum(set_byte(set_byte(Good, 2, 8'h00), 3, 8'h10)), 1'b0, "short");
    chk("short.err_lit", 32'(err_w[0]), 32'b10000);
    chk("short.pl_lit", 32'(pl_w[0]), 0);

    // Reset asserted between clock edges must clear outputs without waiting for an edge.
    send_bytes(Good, 0, 10, 1'b0);
    #2 reset = 1'b1;
    #1;
    exp_done = 1'b0;
    for (int k = 0; k < 3; k++) exp_res[k] = '0;
    check_all("async_reset");
    @(negedge clk);
    rx_dv  = 1'b0;
    rx_sof = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check_all("after_reset");
    send_hdr(Good, 1'b1, "post_reset_good");
    pulse_ack("post_reset_ack");

    for (int n = 0; n < 24; n++) begin
      myip = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hC0A8_00C7;
      h = rand_hdr(32'hC0A8_00C7);
      // Bytes without start of frame outside capture must be ignored.
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_sof  = 1'b0;
        rx_data = 8'($urandom);
      end
      send_hdr(h, ($urandom_range(0, 1) != 0), $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) != 0) pulse_ack($sformatf("rand%0d_ack", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_hchk_rx.md
Name: ip_hchk_rx

Overview:
- Receive-side counterpart of the IP header checksum generator in the GbE path.
- Captures a 20-byte IPv4 header from the byte stream of the Ethernet RX parser and computes the ones'-complement checksum over all ten words.
- Checks version/IHL, fragmentation, total length and destination IP, then presents the parsed fields and a verdict to the UDP/ICMP demux.
- The verdict and fields are held until the demux acknowledges them.

Parameters:
- CHECK_DST, 1, 1 = destination IP must match MyIP (or broadcast when ACCEPT_BCAST=1); 0 = destination check disabled.
- ACCEPT_BCAST, 1, 1 = destination 32'hFFFFFFFF is accepted as a match.

Ports:
- ip_rx_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  header byte; network order, MSB byte first.
- rx_dv  in  1  rx_data is valid this cycle.
- rx_sof  in  1  with rx_dv, marks byte 0 of the IP header.
- MyIP  in  32  local IP address; quasi-static.
- ip_rx_header_ack  in  1  demux has consumed the result.
- ip_HeaderDone  out  1  result and fields are valid; held until acknowledged.
- ip_HeaderValid  out  1  header passed all checks; meaningful only while ip_HeaderDone=1.
- ip_HeaderErr  out  5  error flags: [0] checksum, [1] version/IHL not 8'h45, [2] destination mismatch, [3] fragment (MF=1 or offset≠0), [4] total_len<20.
- ip_total_len  out  16  header bytes 2-3.
- ip_payload_len  out  16  ip_total_len-20, or 0 if ip_total_len<20.
- IpPro  out  8  header byte 9.
- IpSrcIP  out  32  header bytes 12-15.
- IpDstIP  out  32  header bytes 16-19.

Behaviour:
- Reset (async assert): all outputs 0, st=Idle, cnt=0, accumulator=0.
- States: Idle, Collect, Fold1, Fold2, Hold.
- Idle:
  - rx_dv & rx_sof → byte 0 stored, cnt=1, accumulator cleared, go to Collect.
  - rx_dv without rx_sof is ignored.
- Collect:
  - Each rx_dv byte is shifted into a 160-bit header register and increments cnt (5 bits).
  - On odd cnt, the word {prev_byte, rx_data} is added into a 32-bit accumulator.
  - rx_dv=0 pauses capture; there is no timeout.
  - rx_dv & rx_sof restarts capture at byte 0 (the new byte becomes byte 0, accumulator cleared).
  - When byte 19 is accepted (cnt==19), go to Fold1.
- Fold1: s1 = acc[15:0] + acc[31:16], 17-bit result.
- Fold2:
  - s2 = s1[15:0] + s1[16].
  - Checksum is OK iff s2 == 16'hFFFF.
  - Register all fields and error flags.
  - ip_HeaderValid = (ip_HeaderErr == 0).
  - ip_HeaderDone <= 1; go to Hold.
- Latency: ip_HeaderDone rises on the 2nd rising edge after the edge that samples byte 19. Fields and flags become valid on that same edge.
- Hold:
  - Outputs are frozen.
  - ip_rx_header_ack=1 → ip_HeaderDone<=0 next edge, go to Idle. ip_HeaderValid, ip_HeaderErr and the fields keep their values.
  - rx_dv & rx_sof while in Hold (with or without ack):
    - ip_HeaderDone<=0.
    - Capture restarts at byte 0 (direct to Collect).
    - The old result is discarded.
- Bytes arriving in Fold1/Fold2 are dropped. The upstream parser guarantees gaps here; a bench must not drive rx_sof in these states.
- ip_HeaderErr[2] is forced 0 when CHECK_DST=0.
- Destination matches when IpDstIP==MyIP, or when ACCEPT_BCAST=1 and IpDstIP==32'hFFFFFFFF.
- The fragment check uses header bits [111:96] (flags+offset): error if bit 13 (MF) is set or bits [12:0] ≠ 0. DF is ignored.
- Accumulator arithmetic is unsigned 32-bit; 10 words cannot overflow it.
- Reset asserted mid-operation returns to Idle immediately; there is no partial output.

Test Plan:
- Good header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, MyIP=C0A800C7, contiguous rx_dv → Done 2 edges after byte 19, Valid=1, Err=0, total_len=0x0073, payload_len=0x005F, IpPro=0x11, Src=C0A80001, Dst=C0A800C7.
- Same header with checksum bytes B8 62 → Valid=0, Err=5'b00001. Same header with MyIP=C0A80002 → Err=5'b00100. Repeat with CHECK_DST=0 → Valid=1.
- Dst=FFFFFFFF with checksum recomputed, MyIP=C0A800C7 → Valid=1 when ACCEPT_BCAST=1; Err[2]=1 when ACCEPT_BCAST=0.
- Good header with rx_dv gaps (random 0-3 idle cycles), then rx_sof re-asserted at byte 7 followed by a full good header → only the second header is reported; Done stays high through 10 cycles without ack; ack pulse → Done=0 next edge and fields unchanged.
- Byte 0=0x46 with checksum fixed → Err[1]=1. Bytes 6-7=20 00 → Err[3]=1. total_len=0x0010 → Err[4]=1 and payload_len=0. Async reset at byte 10 → all outputs 0 immediately; next good header is reported correctly.
